key_cmd_ctrl: RTL and testbench
===============================

# key_cmd_ctrl

Parametrised successor to the Game-of-Life keyboard controller: consumes PS/2 bytes from the PS/2 receiver and issues one-cycle window and evolution command pulses, the zoom width and the mode flag. It adds full make/break/extended-code parsing, held-key tracking with auto-repeat, and saturating zoom with configurable limits. It sits between the PS/2 receiver and the window/evolution engines.

## Interface
- VW_W, 8: width of view_width.
- VW_MIN, 8: minimum view_width.
- VW_MAX, 128: maximum view_width (must be ≤ 2^VW_W−1).
- VW_STEP, 8: zoom increment/decrement.
- VW_RESET, 32: view_width after reset and after recenter.
- REPEAT_DELAY, 12_500_000: clocks from make to first auto-repeat.
- REPEAT_PERIOD, 2_500_000: clocks between subsequent repeats.

Ports:
- clk  in  1  system clock; one clock domain.
- rst  in  1  asynchronous, active-high reset.
- ps2_byte  in  8  received scan-code byte; stable while ps2_state is high.
- ps2_state  in  1  byte-valid level; each 0→1 transition delivers one byte.
- win_ctrl_cmd  out  7  one-hot pulse: [0] up W 0x1D, [1] down S 0x1B, [2] left A 0x1C, [3] right D 0x23, [4] zoom-in '=' 0x55, [5] zoom-out '-' 0x4E, [6] recenter C 0x21.
- envo_ctrl_cmd  out  7  one-hot pulse: [0] step N 0x31, [1] run/pause Space 0x29, [2] clear X 0x22, [3] random R 0x2D, [4] faster E0 75, [5] slower E0 72, [6] load L 0x4B.
- view_width  out  VW_W  current view width.
- mode  out  1  edit(0)/run(1) mode; toggled by M 0x3A.

## Operation
- Input edge detect: ps2_state registered once; strobe = ps2_state_q & ~ps2_state_qq; byte latched with ps2_state_q. Held-high ps2_state yields exactly one strobe.
- Parser FSM on strobe: IDLE —E0→ EXT; IDLE —F0→ BRK; EXT —F0→ EXT_BRK; any other byte in any state is decoded per state then returns to IDLE. Unmapped codes ignored, FSM returns to IDLE.
- Make of mapped key: one pulse on its command bit (mode toggles, no pulse). Make equal to the currently held key (keyboard typematic) is suppressed.
- Repeatable keys: win[3:0], envo[5:4]. Their make sets held_key and loads the repeat counter with REPEAT_DELAY; counter expiry emits a pulse and reloads REPEAT_PERIOD. Break of held_key clears it; break of any other key has no effect. New repeatable make replaces held_key. Non-repeatable make leaves held_key untouched.
- Zoom: win[4] pulse → view_width = min(view_width+VW_STEP, VW_MAX); win[5] → max(view_width−VW_STEP, VW_MIN); win[6] → VW_RESET. Arithmetic in VW_W+1 bits; no wrap.
- At most one bit set across both command buses per cycle.
- Simultaneous byte-derived command and repeat expiry: byte command wins; repeat counter reloads per new make or continues if the byte was not a make.

## Timing
- Reset values: win_ctrl_cmd=0, envo_ctrl_cmd=0, view_width=VW_RESET, mode=0, FSM=IDLE, held_key=none, counter=0.
- Latency: first clock edge sampling ps2_state=1 is edge k; command pulse and view_width/mode update are registered at edge k+2; pulse lasts exactly one cycle.
- Repeat: first repeat pulse REPEAT_DELAY cycles after the make pulse, then every REPEAT_PERIOD cycles.
- Reset mid-sequence (e.g. between E0 and code) discards the partial sequence and held key.

## Structure
- Package gol_ctrl_pkg: scan-code constants, command bit indices, parser state enum, held-key encoding.
- Sub-module ps2_key_parser: edge detect + FSM, outputs {valid, is_break, is_ext, code}; repeat, zoom and mode logic in key_cmd_ctrl.

## Test plan
(REPEAT_DELAY=10, REPEAT_PERIOD=4, VW_STEP=8, VW_MIN=8, VW_MAX=48, VW_RESET=32)
- 0x23 held 3 cycles → win_ctrl_cmd=7'b0001000 for one cycle at edge k+2; no second pulse.
- 0x1D, no break → pulses at t, t+10, t+14, t+18; then F0 1D → pulses stop.
- 0x55 ×4 → view_width 40, 48, 48, 48; 0x4E ×6 → 40…8, then 8; 0x21 → 32.
- E0 75 → envo_ctrl_cmd=7'b0010000; E0 F0 75 stops repeat; F0 23 while 0x1D held keeps repeating.
- 0x3A twice → mode 1 then 0, no command pulse; unmapped 0x15 → no output, next 0x29 → envo[1] pulse.
- rst asserted after E0 → all outputs reset immediately; next byte 0x72 decodes as non-extended (ignored).

Source files
------------

// File: rtl/gol_ctrl_pkg.sv
// Shared definitions for the Game-of-Life keyboard controller: scan codes,
// command bit positions, parser states and the held-key encoding.
package gol_ctrl_pkg;

   // Prefix bytes
   localparam logic [7:0] SC_EXT    = 8'hE0;
   localparam logic [7:0] SC_BRK    = 8'hF0;

   // Window keys
   localparam logic [7:0] SC_UP     = 8'h1D;
   localparam logic [7:0] SC_DOWN   = 8'h1B;
   localparam logic [7:0] SC_LEFT   = 8'h1C;
   localparam logic [7:0] SC_RIGHT  = 8'h23;
   localparam logic [7:0] SC_ZIN    = 8'h55;
   localparam logic [7:0] SC_ZOUT   = 8'h4E;
   localparam logic [7:0] SC_CENTER = 8'h21;

   // Evolution keys (FASTER/SLOWER only valid after the E0 prefix)
   localparam logic [7:0] SC_STEP   = 8'h31;
   localparam logic [7:0] SC_RUN    = 8'h29;
   localparam logic [7:0] SC_CLEAR  = 8'h22;
   localparam logic [7:0] SC_RANDOM = 8'h2D;
   localparam logic [7:0] SC_FASTER = 8'h75;
   localparam logic [7:0] SC_SLOWER = 8'h72;
   localparam logic [7:0] SC_LOAD   = 8'h4B;
   localparam logic [7:0] SC_MODE   = 8'h3A;

   // Command bit indices
   localparam int WIN_UP = 0, WIN_DOWN = 1, WIN_LEFT = 2, WIN_RIGHT = 3;
   localparam int WIN_ZOOM_IN = 4, WIN_ZOOM_OUT = 5, WIN_CENTER = 6;
   localparam int ENVO_STEP = 0, ENVO_RUN = 1, ENVO_CLEAR = 2, ENVO_RANDOM = 3;
   localparam int ENVO_FASTER = 4, ENVO_SLOWER = 5, ENVO_LOAD = 6;

   typedef enum logic [1:0] {PS_IDLE, PS_EXT, PS_BRK, PS_EXT_BRK} parse_state_e;

   // Only auto-repeating keys can be held
   typedef enum logic [2:0] {
      HK_NONE, HK_UP, HK_DOWN, HK_LEFT, HK_RIGHT, HK_FASTER, HK_SLOWER
   } held_key_e;

   typedef struct packed {
      logic [6:0] win;
      logic [6:0] envo;
      logic       mode_tgl;
      held_key_e  hk;
   } key_dec_t;

   // Map a (prefix, code) pair to its command bits and held-key identity
   function automatic key_dec_t decode_key(input logic is_ext, input logic [7:0] code);
      key_dec_t d;
      d = '0;
      if (is_ext) begin
         case (code)
            SC_FASTER: begin d.envo[ENVO_FASTER] = 1'b1; d.hk = HK_FASTER; end
            SC_SLOWER: begin d.envo[ENVO_SLOWER] = 1'b1; d.hk = HK_SLOWER; end
            default: ;
         endcase
      end else begin
         case (code)
            SC_UP:     begin d.win[WIN_UP]    = 1'b1; d.hk = HK_UP;    end
            SC_DOWN:   begin d.win[WIN_DOWN]  = 1'b1; d.hk = HK_DOWN;  end
            SC_LEFT:   begin d.win[WIN_LEFT]  = 1'b1; d.hk = HK_LEFT;  end
            SC_RIGHT:  begin d.win[WIN_RIGHT] = 1'b1; d.hk = HK_RIGHT; end
            SC_ZIN:    d.win[WIN_ZOOM_IN]   = 1'b1;
            SC_ZOUT:   d.win[WIN_ZOOM_OUT]  = 1'b1;
            SC_CENTER: d.win[WIN_CENTER]    = 1'b1;
            SC_STEP:   d.envo[ENVO_STEP]    = 1'b1;
            SC_RUN:    d.envo[ENVO_RUN]     = 1'b1;
            SC_CLEAR:  d.envo[ENVO_CLEAR]   = 1'b1;
            SC_RANDOM: d.envo[ENVO_RANDOM]  = 1'b1;
            SC_LOAD:   d.envo[ENVO_LOAD]    = 1'b1;
            SC_MODE:   d.mode_tgl           = 1'b1;
            default: ;
         endcase
      end
      return d;
   endfunction

   // Command pulse {envo, win} emitted when a held key auto-repeats
   function automatic logic [13:0] repeat_cmd(input held_key_e hk);
      logic [6:0] win;
      logic [6:0] envo;
      win  = '0;
      envo = '0;
      case (hk)
         HK_UP:     win[WIN_UP]       = 1'b1;
         HK_DOWN:   win[WIN_DOWN]     = 1'b1;
         HK_LEFT:   win[WIN_LEFT]     = 1'b1;
         HK_RIGHT:  win[WIN_RIGHT]    = 1'b1;
         HK_FASTER: envo[ENVO_FASTER] = 1'b1;
         HK_SLOWER: envo[ENVO_SLOWER] = 1'b1;
         default: ;
      endcase
      return {envo, win};
   endfunction

endpackage

// File: rtl/ps2_key_parser.sv
// Turns the byte-valid level from the PS/2 receiver into single strobes and
// assembles E0/F0 prefixed sequences into one decoded key event per key.
module ps2_key_parser
   import gol_ctrl_pkg::*;
(
   input  logic       clk,
   input  logic       rst,
   input  logic [7:0] ps2_byte,
   input  logic       ps2_state,
   output logic       key_valid,
   output logic       key_break,
   output logic       key_ext,
   output logic [7:0] key_code
);

   logic         state_q;
   logic         state_qq;
   logic         strobe;
   logic [7:0]   byte_q;
   parse_state_e state;
   parse_state_e state_nxt;
   logic         valid_nxt;
   logic         break_nxt;
   logic         ext_nxt;

   // Register the byte-valid level and capture the byte alongside it
   // NOTE: sequential state uses <= so every flop samples pre-edge values.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q  <= 1'b0;
         state_qq <= 1'b0;
         byte_q   <= '0;
      end else begin
         state_q  <= ps2_state;
         state_qq <= state_q;
         if (ps2_state) byte_q <= ps2_byte;
      end
   end

   // One strobe per rising edge of the byte-valid level
   assign strobe = state_q & ~state_qq;

   // Prefix tracking and event decode
   always_comb begin
      // NOTE: every output of this block gets a default first so no latch is inferred.
      state_nxt = state;
      valid_nxt = 1'b0;
      break_nxt = 1'b0;
      ext_nxt   = 1'b0;
      if (strobe) begin
         state_nxt = PS_IDLE;
         case (state)
            PS_IDLE: begin
               if (byte_q == SC_EXT)      state_nxt = PS_EXT;
               else if (byte_q == SC_BRK) state_nxt = PS_BRK;
               else                       valid_nxt = 1'b1;
            end
            PS_EXT: begin
               if (byte_q == SC_BRK) begin
                  state_nxt = PS_EXT_BRK;
               end else begin
                  valid_nxt = 1'b1;
                  ext_nxt   = 1'b1;
               end
            end
            PS_BRK: begin
               valid_nxt = 1'b1;
               break_nxt = 1'b1;
            end
            default: begin
               valid_nxt = 1'b1;
               break_nxt = 1'b1;
               ext_nxt   = 1'b1;
            end
         endcase
      end
   end

   // Parser state and registered event outputs
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state     <= PS_IDLE;
         key_valid <= 1'b0;
         key_break <= 1'b0;
         key_ext   <= 1'b0;
         key_code  <= '0;
      end else begin
         state     <= state_nxt;
         key_valid <= valid_nxt;
         key_break <= break_nxt;
         key_ext   <= ext_nxt;
         if (valid_nxt) key_code <= byte_q;
      end
   end

endmodule

// File: rtl/key_cmd_ctrl.sv
// Keyboard command controller: maps decoded key events to one-cycle window
// and evolution command pulses, auto-repeats held navigation/speed keys,
// tracks the saturating zoom width and the edit/run mode flag.
module key_cmd_ctrl
   import gol_ctrl_pkg::*;
#(
   parameter int VW_W          = 8,
   parameter int VW_MIN        = 8,
   parameter int VW_MAX        = 128,
   parameter int VW_STEP       = 8,
   parameter int VW_RESET      = 32,
   parameter int REPEAT_DELAY  = 12_500_000,
   parameter int REPEAT_PERIOD = 2_500_000
) (
   input  logic            clk,
   input  logic            rst,
   input  logic [7:0]      ps2_byte,
   input  logic            ps2_state,
   output logic [6:0]      win_ctrl_cmd,
   output logic [6:0]      envo_ctrl_cmd,
   output logic [VW_W-1:0] view_width,
   output logic            mode
);

   localparam int CNT_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
   localparam int CNT_W   = $clog2(CNT_MAX + 1);

   typedef logic [VW_W-1:0]  vw_t;
   typedef logic [VW_W:0]    vw_x_t;
   typedef logic [CNT_W-1:0] cnt_t;

   logic       key_valid;
   logic       key_break;
   logic       key_ext;
   logic [7:0] key_code;

   key_dec_t   dec;
   logic       make_hit;
   logic [6:0] win_nxt;
   logic [6:0] envo_nxt;
   logic       mode_nxt;
   vw_t        vw_nxt;
   vw_x_t      vw_sum;
   vw_x_t      vw_dif;
   held_key_e  held_key;
   held_key_e  held_nxt;
   cnt_t       rpt_cnt;
   cnt_t       cnt_nxt;

   ps2_key_parser u_parser (
      .clk       (clk),
      .rst       (rst),
      .ps2_byte  (ps2_byte),
      .ps2_state (ps2_state),
      .key_valid (key_valid),
      .key_break (key_break),
      .key_ext   (key_ext),
      .key_code  (key_code)
   );

   // Zoom arithmetic one bit wider than view_width so neither side can wrap
   assign vw_sum = {1'b0, view_width} + vw_x_t'(VW_STEP);
   assign vw_dif = {1'b0, view_width} - vw_x_t'(VW_STEP);

   // Command selection: auto-repeat first, then byte-derived events override it
   always_comb begin
      dec      = decode_key(key_ext, key_code);
      win_nxt  = '0;
      envo_nxt = '0;
      mode_nxt = mode;
      held_nxt = held_key;
      cnt_nxt  = rpt_cnt;
      vw_nxt   = view_width;

      // Typematic re-sends of the held key carry no new information
      make_hit = key_valid && !key_break
                 && ((dec.win != '0) || (dec.envo != '0) || dec.mode_tgl)
                 && !((dec.hk != HK_NONE) && (dec.hk == held_key));

      if (held_key != HK_NONE) begin
         if (rpt_cnt == cnt_t'(1)) begin
            {envo_nxt, win_nxt} = repeat_cmd(held_key);
            cnt_nxt             = cnt_t'(REPEAT_PERIOD);
         end else begin
            cnt_nxt = rpt_cnt - cnt_t'(1);
         end
      end

      if (key_valid && key_break && (dec.hk != HK_NONE) && (dec.hk == held_key)) begin
         held_nxt = HK_NONE;
         cnt_nxt  = '0;
         win_nxt  = '0;
         envo_nxt = '0;
      end

      if (make_hit) begin
         win_nxt  = dec.win;
         envo_nxt = dec.envo;
         mode_nxt = mode ^ dec.mode_tgl;
         if (dec.hk != HK_NONE) begin
            held_nxt = dec.hk;
            cnt_nxt  = cnt_t'(REPEAT_DELAY);
         end
      end

      if (win_nxt[WIN_ZOOM_IN]) begin
         vw_nxt = (vw_sum > vw_x_t'(VW_MAX)) ? vw_t'(VW_MAX) : vw_sum[VW_W-1:0];
      end else if (win_nxt[WIN_ZOOM_OUT]) begin
         vw_nxt = (vw_dif[VW_W] || (vw_dif < vw_x_t'(VW_MIN))) ? vw_t'(VW_MIN)
                                                               : vw_dif[VW_W-1:0];
      end else if (win_nxt[WIN_CENTER]) begin
         vw_nxt = vw_t'(VW_RESET);
      end
   end

   // Registered command pulses, view state and repeat tracking
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         win_ctrl_cmd  <= '0;
         envo_ctrl_cmd <= '0;
         view_width    <= vw_t'(VW_RESET);
         mode          <= 1'b0;
         held_key      <= HK_NONE;
         rpt_cnt       <= '0;
      end else begin
         win_ctrl_cmd  <= win_nxt;
         envo_ctrl_cmd <= envo_nxt;
         view_width    <= vw_nxt;
         mode          <= mode_nxt;
         held_key      <= held_nxt;
         rpt_cnt       <= cnt_nxt;
      end
   end

endmodule

// File: tb/tb_key_cmd_ctrl.sv
// Directed bench for key_cmd_ctrl: a table of key sequences with expected
// outputs, plus hand-written sequences for auto-repeat and reset corners.
module tb_key_cmd_ctrl;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic [7:0] ps2_byte = 8'h00;
   logic       ps2_state = 1'b0;
   logic [6:0] win_ctrl_cmd;
   logic [6:0] envo_ctrl_cmd;
   logic [7:0] view_width;
   logic       mode;

   int n_checks = 0;
   int n_errors = 0;
   int cyc = 0;
   int last_k = 0;

   typedef struct {
      int         cyc;
      logic [6:0] win;
      logic [6:0] envo;
   } pulse_t;
   pulse_t log_q[$];

   typedef struct {
      string      name;
      int         n;
      logic [7:0] b0, b1, b2;
      int         hold;
      logic [6:0] win, envo;
      logic [7:0] vw;
      logic       mode;
   } vec_t;
   vec_t vecs[$];

   key_cmd_ctrl #(
      .VW_W(8), .VW_MIN(8), .VW_MAX(48), .VW_STEP(8), .VW_RESET(32),
      .REPEAT_DELAY(10), .REPEAT_PERIOD(4)
   ) dut (
      .clk           (clk),
      .rst           (rst),
      .ps2_byte      (ps2_byte),
      .ps2_state     (ps2_state),
      .win_ctrl_cmd  (win_ctrl_cmd),
      .envo_ctrl_cmd (envo_ctrl_cmd),
      .view_width    (view_width),
      .mode          (mode)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   // Log every command pulse and require it to be a single bit
   always @(negedge clk) begin
      if (!rst && (win_ctrl_cmd != '0 || envo_ctrl_cmd != '0)) begin
         log_q.push_back('{cyc, win_ctrl_cmd, envo_ctrl_cmd});
         check("onehot", 32'($countones({win_ctrl_cmd, envo_ctrl_cmd})), 32'd1);
      end
   end

   initial begin
      #500_000;
      $display("FAIL watchdog: simulation did not complete, expected completion");
      $fatal(1, "watchdog");
   end

   // Present one byte; the first edge sampling it high is recorded as last_k
   task automatic send_byte(input logic [7:0] b, input int hold);
      @(negedge clk);
      ps2_byte  = b;
      ps2_state = 1'b1;
      last_k    = cyc + 1;
      repeat (hold) @(negedge clk);
      ps2_state = 1'b0;
   endtask

   task automatic wait_until(input int c);
      while (cyc < c) @(negedge clk);
   endtask

   function automatic vec_t mk(input string name, input int n, input logic [7:0] b0,
                               input logic [7:0] b1, input logic [7:0] b2, input int hold,
                               input logic [6:0] win, input logic [6:0] envo,
                               input logic [7:0] vw, input logic m);
      vec_t v;
      v = '{name, n, b0, b1, b2, hold, win, envo, vw, m};
      return v;
   endfunction

   initial begin
      int         t;
      int         offs[4];
      logic [7:0] bs[3];
      offs = '{0, 10, 14, 18};

      vecs.push_back(mk("right_hold3", 1, 8'h23, 0, 0, 3, 7'h08, 7'h00, 32, 0));
      vecs.push_back(mk("right_brk",   2, 8'hF0, 8'h23, 0, 1, 7'h00, 7'h00, 32, 0));
      vecs.push_back(mk("zin1",  1, 8'h55, 0, 0, 2, 7'h10, 7'h00, 40, 0));
      vecs.push_back(mk("zin2",  1, 8'h55, 0, 0, 2, 7'h10, 7'h00, 48, 0));
      vecs.push_back(mk("zin3",  1, 8'h55, 0, 0, 2, 7'h10, 7'h00, 48, 0));
      vecs.push_back(mk("zin4",  1, 8'h55, 0, 0, 2, 7'h10, 7'h00, 48, 0));
      vecs.push_back(mk("zout1", 1, 8'h4E, 0, 0, 2, 7'h20, 7'h00, 40, 0));
      vecs.push_back(mk("zout2", 1, 8'h4E, 0, 0, 2, 7'h20, 7'h00, 32, 0));
      vecs.push_back(mk("zout3", 1, 8'h4E, 0, 0, 2, 7'h20, 7'h00, 24, 0));
      vecs.push_back(mk("zout4", 1, 8'h4E, 0, 0, 2, 7'h20, 7'h00, 16, 0));
      vecs.push_back(mk("zout5", 1, 8'h4E, 0, 0, 2, 7'h20, 7'h00, 8, 0));
      vecs.push_back(mk("zout6", 1, 8'h4E, 0, 0, 2, 7'h20, 7'h00, 8, 0));
      vecs.push_back(mk("recenter", 1, 8'h21, 0, 0, 2, 7'h40, 7'h00, 32, 0));
      vecs.push_back(mk("mode_on",  1, 8'h3A, 0, 0, 2, 7'h00, 7'h00, 32, 1));
      vecs.push_back(mk("mode_off", 1, 8'h3A, 0, 0, 2, 7'h00, 7'h00, 32, 0));
      vecs.push_back(mk("unmapped", 1, 8'h15, 0, 0, 2, 7'h00, 7'h00, 32, 0));
      vecs.push_back(mk("run",      1, 8'h29, 0, 0, 2, 7'h00, 7'h02, 32, 0));
      vecs.push_back(mk("faster",     2, 8'hE0, 8'h75, 0, 2, 7'h00, 7'h10, 32, 0));
      vecs.push_back(mk("faster_brk", 3, 8'hE0, 8'hF0, 8'h75, 1, 7'h00, 7'h00, 32, 0));
      vecs.push_back(mk("step",   1, 8'h31, 0, 0, 2, 7'h00, 7'h01, 32, 0));
      vecs.push_back(mk("clear",  1, 8'h22, 0, 0, 2, 7'h00, 7'h04, 32, 0));
      vecs.push_back(mk("random", 1, 8'h2D, 0, 0, 2, 7'h00, 7'h08, 32, 0));
      vecs.push_back(mk("load",   1, 8'h4B, 0, 0, 2, 7'h00, 7'h40, 32, 0));
      vecs.push_back(mk("slower",     2, 8'hE0, 8'h72, 0, 2, 7'h00, 7'h20, 32, 0));
      vecs.push_back(mk("slower_brk", 3, 8'hE0, 8'hF0, 8'h72, 1, 7'h00, 7'h00, 32, 0));
      vecs.push_back(mk("down",     1, 8'h1B, 0, 0, 2, 7'h02, 7'h00, 32, 0));
      vecs.push_back(mk("down_brk", 2, 8'hF0, 8'h1B, 0, 1, 7'h00, 7'h00, 32, 0));
      vecs.push_back(mk("left",     1, 8'h1C, 0, 0, 2, 7'h04, 7'h00, 32, 0));
      vecs.push_back(mk("left_brk", 2, 8'hF0, 8'h1C, 0, 1, 7'h00, 7'h00, 32, 0));

      // Reset state
      repeat (3) @(negedge clk);
      check("rst.win",  32'(win_ctrl_cmd), 32'h0);
      check("rst.envo", 32'(envo_ctrl_cmd), 32'h0);
      check("rst.vw",   32'(view_width), 32'd32);
      check("rst.mode", 32'(mode), 32'h0);
      rst = 1'b0;
      repeat (2) @(negedge clk);

      // Table: outputs at edge k+2 of the last byte, nothing at k+3
      foreach (vecs[i]) begin
         bs = '{vecs[i].b0, vecs[i].b1, vecs[i].b2};
         for (int j = 0; j < vecs[i].n; j++) send_byte(bs[j], vecs[i].hold);
         wait_until(last_k + 2);
         check({vecs[i].name, ".win"},  32'(win_ctrl_cmd),  32'(vecs[i].win));
         check({vecs[i].name, ".envo"}, 32'(envo_ctrl_cmd), 32'(vecs[i].envo));
         check({vecs[i].name, ".vw"},   32'(view_width),    32'(vecs[i].vw));
         check({vecs[i].name, ".mode"}, 32'(mode),          32'(vecs[i].mode));
         @(negedge clk);
         check({vecs[i].name, ".win_k3"},  32'(win_ctrl_cmd),  32'h0);
         check({vecs[i].name, ".envo_k3"}, 32'(envo_ctrl_cmd), 32'h0);
      end

      // Auto-repeat of W; break of another key and typematic make are ignored
      repeat (20) @(negedge clk);
      log_q.delete();
      send_byte(8'h1D, 2);
      t = last_k + 2;
      wait_until(t);
      send_byte(8'hF0, 1);
      send_byte(8'h23, 1);
      send_byte(8'h1D, 1);
      wait_until(t + 13);
      send_byte(8'hF0, 1);
      send_byte(8'h1D, 1);
      wait_until(t + 40);
      check("rpt.count", 32'(log_q.size()), 32'd4);
      for (int i = 0; i < 4 && i < log_q.size(); i++) begin
         check($sformatf("rpt.cyc%0d", i), 32'(log_q[i].cyc), 32'(t + offs[i]));
         check($sformatf("rpt.win%0d", i), 32'(log_q[i].win), 32'h01);
         check($sformatf("rpt.envo%0d", i), 32'(log_q[i].envo), 32'h00);
      end

      // Reset between E0 and the code discards the prefix and all state
      send_byte(8'h3A, 2);
      wait_until(last_k + 3);
      send_byte(8'h55, 2);
      wait_until(last_k + 3);
      check("pre_rst.mode", 32'(mode), 32'h1);
      check("pre_rst.vw",   32'(view_width), 32'd40);
      send_byte(8'hE0, 2);
      @(negedge clk);
      rst = 1'b1;
      #1;
      check("mid_rst.mode", 32'(mode), 32'h0);
      check("mid_rst.vw",   32'(view_width), 32'd32);
      check("mid_rst.cmd",  32'({win_ctrl_cmd, envo_ctrl_cmd}), 32'h0);
      @(negedge clk);
      rst = 1'b0;
      log_q.delete();
      send_byte(8'h72, 2);
      wait_until(last_k + 8);
      check("post_rst.pulses", 32'(log_q.size()), 32'd0);
      check("post_rst.vw",     32'(view_width), 32'd32);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
